// File: rtl/usbf_pa_len_pkg.sv
// rtl/usbf_pa_len_pkg.sv - PID constants, FSM state encoding and bit helpers for the packet assembler
package usbf_pa_len_pkg;

  localparam logic [3:0] USBF_T_PID_ACK   = 4'b0010;
  localparam logic [3:0] USBF_T_PID_NACK  = 4'b1010;
  localparam logic [3:0] USBF_T_PID_STALL = 4'b1110;
  localparam logic [3:0] USBF_T_PID_NYET  = 4'b0110;
  localparam logic [3:0] USBF_T_PID_DATA0 = 4'b0011;
  localparam logic [3:0] USBF_T_PID_DATA1 = 4'b1011;
  localparam logic [3:0] USBF_T_PID_DATA2 = 4'b0111;
  localparam logic [3:0] USBF_T_PID_MDATA = 4'b1111;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_HS   = 6'b000010,
    ST_PID  = 6'b000100,
    ST_DATA = 6'b001000,
    ST_CRC1 = 6'b010000,
    ST_CRC2 = 6'b100000
  } pa_state_t;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

  function automatic logic [3:0] token_pid(input logic [1:0] sel);
    case (sel)
      2'd0:    return USBF_T_PID_ACK;
      2'd1:    return USBF_T_PID_NACK;
      2'd2:    return USBF_T_PID_STALL;
      default: return USBF_T_PID_NYET;
    endcase
  endfunction

  function automatic logic [3:0] data_pid(input logic [1:0] sel);
    case (sel)
      2'd0:    return USBF_T_PID_DATA0;
      2'd1:    return USBF_T_PID_DATA1;
      2'd2:    return USBF_T_PID_DATA2;
      default: return USBF_T_PID_MDATA;
    endcase
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/usbf_crc16.sv
// rtl/usbf_crc16.sv - one-byte CRC16 (poly 8005) update, MSB-first over din
module usbf_crc16
  import usbf_pa_len_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  din,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ (((c[15] ^ din[i]) == 1'b1) ? CRC16_POLY : 16'h0000);
    end
    crc_out = c;
  end

endmodule

// File: rtl/usbf_pa_len.sv
// rtl/usbf_pa_len.sv - length-driven USB handshake/data packet assembler onto UTMI TX
module usbf_pa_len
  import usbf_pa_len_pkg::*;
#(
  parameter int LEN_W   = 11,
  parameter int MAX_LEN = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_token,
  input  logic [1:0]       token_pid_sel,
  input  logic             send_data,
  input  logic [1:0]       data_pid_sel,
  input  logic [LEN_W-1:0] data_len,
  input  logic             abort,
  input  logic [7:0]       tx_data_st,
  output logic             rd_next,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_first,
  output logic             tx_valid_last,
  output logic             busy,
  output logic             done,
  output logic             len_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  pa_state_t        state;
  logic [7:0]       pid_q;
  logic [LEN_W-1:0] cnt;
  logic [15:0]      crc;
  logic [15:0]      crc_next;
  logic             accept;

  // abort wins over a same-cycle accept, so the byte is treated as unsent
  assign accept = tx_valid & tx_ready & ~abort;

  usbf_crc16 u_crc16 (
    .crc_in  (crc),
    .din     (bitrev8(tx_data_st)),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pid_q   <= 8'h00;
      cnt     <= '0;
      crc     <= CRC16_INIT;
      done    <= 1'b0;
      len_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      len_err <= 1'b0;
      if (state != ST_IDLE && abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (send_token) begin
              pid_q <= pid_byte(token_pid(token_pid_sel));
              state <= ST_HS;
            end else if (send_data) begin
              if (data_len > MAX_LEN_V) begin
                len_err <= 1'b1;
              end else begin
                pid_q <= pid_byte(data_pid(data_pid_sel));
                cnt   <= data_len;
                state <= ST_PID;
              end
            end
          end
          ST_HS: begin
            if (accept) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          ST_PID: begin
            crc <= CRC16_INIT;
            if (accept) state <= (cnt != '0) ? ST_DATA : ST_CRC1;
          end
          ST_DATA: begin
            if (accept) begin
              crc <= crc_next;
              cnt <= cnt - LEN_W'(1);
              if (cnt == LEN_W'(1)) state <= ST_CRC1;
            end
          end
          ST_CRC1: begin
            if (accept) state <= ST_CRC2;
          end
          ST_CRC2: begin
            if (accept) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy          = (state != ST_IDLE);
  assign tx_valid      = busy;
  assign tx_first      = (state == ST_HS) || (state == ST_PID);
  assign tx_valid_last = (state == ST_HS) || (state == ST_CRC2);
  assign rd_next       = (state == ST_DATA) && accept;

  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_HS, ST_PID: tx_data = pid_q;
      ST_DATA:       tx_data = tx_data_st;
      ST_CRC1:       tx_data = ~bitrev8(crc[15:8]);
      ST_CRC2:       tx_data = ~bitrev8(crc[7:0]);
      default:       tx_data = 8'h00;
    endcase
  end

endmodule
